// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment capture decoder: glyph table,
// segment bit positions and FSM state encoding.
package seg7_pkg;

  // Bit positions inside a segment bus {g,f,e,d,c,b,a}; a lit segment reads 0.
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_HEX_A, SEG_HEX_B, SEG_HEX_C, SEG_HEX_D, SEG_HEX_E, SEG_HEX_F
  };

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLING = 2'd1,
    ST_STABLE   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational glyph decoder: one active-low segment pattern to a hex nibble.
// Blank and every non-glyph pattern report legal = 0.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPH[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Monitors four seven-segment buses, waits for a stable frame and publishes
// the decoded 16-bit word, flagging frames that contain illegal glyphs.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  a2_h,
  input  logic [6:0]  a1_h,
  input  logic [6:0]  b2_h,
  input  logic [6:0]  b1_h,
  output logic [15:0] word,
  output logic        word_valid,
  output logic        err,
  output logic [3:0]  bad_mask,
  output logic        stable
);

  localparam logic [7:0]  CNT_MAX    = 8'(STABLE_CYCLES);
  localparam logic [27:0] FRAME_BLANK = {4{SEG_BLANK}};

  logic [27:0] sample;
  logic [27:0] snap_q, snap_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic        pub_q, pub_d;
  logic [15:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        err_q, err_d;
  logic [3:0]  bad_mask_q, bad_mask_d;
  logic        stable_q, stable_d;

  logic [3:0]  legal;
  logic [15:0] dec_word;
  logic        changed;
  logic        all_blank;

  assign sample = {a2_h, a1_h, b2_h, b1_h};

  // Digit gi sits at snap[7*gi +: 7]; index 3 is a2, index 0 is b1.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    seg7_digit_decode u_dec (
      .seg    (snap_q[7*gi +: 7]),
      .legal  (legal[gi]),
      .nibble (dec_word[4*gi +: 4])
    );
  end

  assign changed   = (sample != snap_q);
  assign all_blank = (snap_q == FRAME_BLANK);

  always_comb begin
    snap_d       = sample;
    cnt_d        = cnt_q;
    state_d      = state_q;
    pub_d        = pub_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;
    bad_mask_d   = bad_mask_q;

    if (changed) begin
      cnt_d   = 8'd0;
      state_d = ST_SETTLING;
    end else begin
      cnt_d = (cnt_q < CNT_MAX) ? cnt_q + 8'd1 : cnt_q;
      if (state_q == ST_SETTLING && cnt_q == CNT_MAX - 8'd1) begin
        if (all_blank) begin
          state_d    = ST_IDLE;
          bad_mask_d = 4'b0000;
        end else begin
          state_d = ST_STABLE;
          if (&legal) begin
            bad_mask_d = 4'b0000;
            // A repeat of the published word stays silent unless an error intervened.
            if (!pub_q || dec_word != word_q) begin
              word_d       = dec_word;
              word_valid_d = 1'b1;
              pub_d        = 1'b1;
            end
          end else begin
            err_d      = 1'b1;
            bad_mask_d = ~legal;
            pub_d      = 1'b0;
          end
        end
      end
    end

    stable_d = (state_d == ST_STABLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_q       <= FRAME_BLANK;
      cnt_q        <= 8'd0;
      state_q      <= ST_IDLE;
      pub_q        <= 1'b0;
      word_q       <= 16'h0000;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
      bad_mask_q   <= 4'b0000;
      stable_q     <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      pub_q        <= pub_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
      bad_mask_q   <= bad_mask_d;
      stable_q     <= stable_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign err        = err_q;
  assign bad_mask   = bad_mask_q;
  assign stable     = stable_q;

endmodule
